// File: rtl/mwmr_ram.sv
// Multi-write / multi-read register-file RAM with registered read data,
// optional same-cycle write forwarding and a self-clearing sweep after reset or clr.
module mwmr_ram #(
    parameter int unsigned ENTRY_CNT   = 32,
    parameter int unsigned ENTRY_WIDTH = 32,
    parameter int unsigned R_PORT      = 2,
    parameter int unsigned W_PORT      = 2,
    parameter int unsigned BYPASS      = 1,
    parameter logic [ENTRY_WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned AW = $clog2(ENTRY_CNT)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [W_PORT-1:0]                   wr,
    input  logic [W_PORT-1:0][AW-1:0]           wadr,
    input  logic [W_PORT-1:0][ENTRY_WIDTH-1:0]  wdat,
    input  logic [R_PORT-1:0]                   rd,
    input  logic [R_PORT-1:0][AW-1:0]           radr,
    output logic [R_PORT-1:0][ENTRY_WIDTH-1:0]  rdat,
    output logic [R_PORT-1:0]                   rvalid,
    input  logic                                clr,
    output logic                                busy
);

    localparam logic [0:0]    S_CLEAR = 1'b0;
    localparam logic [0:0]    S_IDLE  = 1'b1;
    localparam logic [AW-1:0] LAST    = AW'(ENTRY_CNT - 1);

    logic [0:0]                          state, state_nxt;
    logic [AW-1:0]                       cnt, cnt_nxt;
    logic                                busy_nxt;
    logic [R_PORT-1:0][ENTRY_WIDTH-1:0]  rdat_nxt;
    logic [R_PORT-1:0]                   rvalid_nxt;
    logic [R_PORT-1:0][ENTRY_WIDTH-1:0]  fwd_data;
    logic [ENTRY_WIDTH-1:0]              mem [ENTRY_CNT];

    // Storage array: no reset, contents defined only by the sweep and accepted writes.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= INIT_VALUE;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins a collision.
            for (int unsigned j = 0; j < W_PORT; j++) begin
                if (wr[j] && (32'(wadr[j]) < ENTRY_CNT)) begin
                    mem[wadr[j]] <= wdat[j];
                end
            end
        end
    end

    // Per-port read value, including forwarding from the winning same-cycle write.
    always_comb begin
        fwd_data = '0;
        for (int unsigned i = 0; i < R_PORT; i++) begin
            fwd_data[i] = INIT_VALUE;
            if (32'(radr[i]) < ENTRY_CNT) begin
                fwd_data[i] = mem[radr[i]];
                if (BYPASS != 0) begin
                    for (int unsigned j = 0; j < W_PORT; j++) begin
                        if (wr[j] && (wadr[j] == radr[i])) begin
                            fwd_data[i] = wdat[j];
                        end
                    end
                end
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            rdat   <= '0;
            rvalid <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            rdat   <= rdat_nxt;
            rvalid <= rvalid_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rdat_nxt   = rdat;
        rvalid_nxt = '0;
        if (state == S_CLEAR) begin
            if (cnt == LAST) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + AW'(1);
            end
        end else begin
            for (int unsigned i = 0; i < R_PORT; i++) begin
                if (rd[i]) begin
                    rdat_nxt[i]   = fwd_data[i];
                    rvalid_nxt[i] = 1'b1;
                end
            end
            if (clr) begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        end
        busy_nxt = (state_nxt == S_CLEAR);
    end

endmodule

// File: tb/tb_mwmr_ram.sv
// Bench for mwmr_ram: two instances (32 entries with forwarding, 24 entries without,
// nonzero init) driven in lockstep and compared every cycle against an array model.
module tb_mwmr_ram;

    localparam int unsigned AW     = 5;
    localparam int unsigned EW     = 32;
    localparam logic [31:0] INIT_B = 32'hDEAD_BEEF;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             wr;
    logic [1:0][AW-1:0]     wadr;
    logic [1:0][EW-1:0]     wdat;
    logic [1:0]             rd;
    logic [1:0][AW-1:0]     radr;
    logic                   clr;
    logic [1:0][EW-1:0]     rdat_a, rdat_b;
    logic [1:0]             rvalid_a, rvalid_b;
    logic                   busy_a, busy_b;

    always #5 clk = ~clk;

    mwmr_ram #(.ENTRY_CNT(32), .ENTRY_WIDTH(32), .R_PORT(2), .W_PORT(2),
               .BYPASS(1), .INIT_VALUE(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wadr(wadr), .wdat(wdat),
        .rd(rd), .radr(radr), .rdat(rdat_a), .rvalid(rvalid_a),
        .clr(clr), .busy(busy_a));

    mwmr_ram #(.ENTRY_CNT(24), .ENTRY_WIDTH(32), .R_PORT(2), .W_PORT(2),
               .BYPASS(0), .INIT_VALUE(INIT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wadr(wadr), .wdat(wdat),
        .rd(rd), .radr(radr), .rdat(rdat_b), .rvalid(rvalid_b),
        .clr(clr), .busy(busy_b));

    int checks;
    int errors;

    // Reference model: per instance an entry array, remaining sweep cycles, and output images.
    int          n_ent [2];
    bit          byp   [2];
    logic [31:0] initv [2];
    logic [31:0] mm    [2][32];
    int          rem   [2];
    logic [31:0] mrdat [2][2];
    logic [1:0]  mrv   [2];

    typedef struct {
        logic [1:0]  wr;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  rd;
        logic [4:0]  ra0, ra1;
        logic [31:0] ea, eb;
        logic        eva, evb;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k] = n_ent[k];
            mrv[k] = '0;
            for (int i = 0; i < 2; i++) mrdat[k][i] = '0;
        end
    endtask

    task automatic model_step();
        logic [31:0] v;
        int          a;
        for (int k = 0; k < 2; k++) begin
            if (rem[k] > 0) begin
                rem[k]--;
                mrv[k] = '0;
                if (rem[k] == 0)
                    for (int e = 0; e < n_ent[k]; e++) mm[k][e] = initv[k];
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (rd[i]) begin
                        a = int'(radr[i]);
                        if (a >= n_ent[k]) v = initv[k];
                        else begin
                            v = mm[k][a];
                            if (byp[k])
                                for (int j = 0; j < 2; j++)
                                    if (wr[j] && int'(wadr[j]) == a) v = wdat[j];
                        end
                        mrdat[k][i] = v;
                        mrv[k][i]   = 1'b1;
                    end else begin
                        mrv[k][i] = 1'b0;
                    end
                end
                for (int j = 0; j < 2; j++)
                    if (wr[j] && int'(wadr[j]) < n_ent[k]) mm[k][int'(wadr[j])] = wdat[j];
                if (clr) rem[k] = n_ent[k];
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk($sformatf("%s busy_a", tag), 32'(busy_a), 32'(rem[0] > 0));
        chk($sformatf("%s busy_b", tag), 32'(busy_b), 32'(rem[1] > 0));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s rdat_a[%0d]", tag, i), rdat_a[i], mrdat[0][i]);
            chk($sformatf("%s rdat_b[%0d]", tag, i), rdat_b[i], mrdat[1][i]);
            chk($sformatf("%s rvalid_a[%0d]", tag, i), 32'(rvalid_a[i]), 32'(mrv[0][i]));
            chk($sformatf("%s rvalid_b[%0d]", tag, i), 32'(rvalid_b[i]), 32'(mrv[1][i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        check_outputs($sformatf("t=%0t", $time));
    endtask

    task automatic idle_inputs();
        wr = '0; rd = '0; clr = 1'b0;
        wadr = '0; wdat = '0; radr = '0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 2) == 0) return AW'($urandom_range(4, 8));
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic randomize_inputs(input int clr_odds);
        wr = 2'($urandom);
        rd = 2'($urandom);
        for (int j = 0; j < 2; j++) begin
            wadr[j] = pick_addr();
            wdat[j] = $urandom;
            radr[j] = pick_addr();
        end
        clr = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
    endtask

    // Asynchronous reset taken between clock edges, held for a few cycles.
    task automatic async_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst busy_a", 32'(busy_a), 32'd1);
        chk("rst busy_b", 32'(busy_b), 32'd1);
        chk("rst rdat_a0", rdat_a[0], 32'd0);
        chk("rst rdat_b1", rdat_b[1], 32'd0);
        chk("rst rvalid_a", 32'(rvalid_a), 32'd0);
        check_outputs("rst");
        repeat (hold) tick();
    endtask

    // Edges until each busy drops; optionally random traffic (and stray clr) during the sweep.
    task automatic count_busy(input bit rand_in, output int la, output int lb);
        la = -1;
        lb = -1;
        for (int n = 1; n <= 100; n++) begin
            if (rand_in) begin
                randomize_inputs(2);
                if (!busy_b) clr = 1'b0;
            end
            tick();
            if (la < 0 && !busy_a) la = n;
            if (lb < 0 && !busy_b) lb = n;
            if (la >= 0 && lb >= 0) break;
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            rd = 2'b11;
            radr[0] = AW'(a);
            radr[1] = AW'(31 - a);
            tick();
        end
        rd = '0;
        tick();
    endtask

    initial begin
        int la, lb;
        checks = 0;
        errors = 0;
        n_ent[0] = 32; byp[0] = 1'b1; initv[0] = 32'h0;
        n_ent[1] = 24; byp[1] = 1'b0; initv[1] = INIT_B;

        //            wr     wa0 wa1 wd0            wd1            rd     ra0 ra1 ea             eb             eva evb
        tbl[0] = '{2'b11, 5, 5, 32'h0000_AAAA, 32'h0000_5555, 2'b00, 0, 0, 32'h0,         INIT_B,        0, 0};
        tbl[1] = '{2'b00, 0, 0, 32'h0,         32'h0,         2'b01, 5, 0, 32'h0000_5555, 32'h0000_5555, 1, 1};
        tbl[2] = '{2'b01, 7, 0, 32'h0000_1234, 32'h0,         2'b01, 7, 0, 32'h0000_1234, INIT_B,        1, 1};
        tbl[3] = '{2'b00, 0, 0, 32'h0,         32'h0,         2'b01, 7, 0, 32'h0000_1234, 32'h0000_1234, 1, 1};
        tbl[4] = '{2'b01, 30, 0, 32'h0000_0BAD, 32'h0,        2'b00, 0, 0, 32'h0000_1234, 32'h0000_1234, 0, 0};
        tbl[5] = '{2'b00, 0, 0, 32'h0,         32'h0,         2'b01, 30, 0, 32'h0000_0BAD, INIT_B,       1, 1};
        tbl[6] = '{2'b00, 0, 0, 32'h0,         32'h0,         2'b00, 30, 0, 32'h0000_0BAD, INIT_B,       0, 0};
        tbl[7] = '{2'b11, 9, 9, 32'h0000_1111, 32'h0000_2222, 2'b01, 9, 0, 32'h0000_2222, INIT_B,        1, 1};
        tbl[8] = '{2'b00, 0, 0, 32'h0,         32'h0,         2'b11, 9, 9, 32'h0000_2222, 32'h0000_2222, 1, 1};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        async_reset(2);
        rst_n = 1'b1;

        // Power-up sweep length, then every entry reads the init value.
        count_busy(1'b0, la, lb);
        chk("sweep len a", 32'(la), 32'd32);
        chk("sweep len b", 32'(lb), 32'd24);
        read_all();
        chk("post-read rvalid_a", 32'(rvalid_a), 32'd0);

        // Directed vectors: collisions, forwarding, out-of-range, hold.
        for (int v = 0; v < 9; v++) begin
            wr = tbl[v].wr;
            wadr[0] = tbl[v].wa0; wadr[1] = tbl[v].wa1;
            wdat[0] = tbl[v].wd0; wdat[1] = tbl[v].wd1;
            rd = tbl[v].rd;
            radr[0] = tbl[v].ra0; radr[1] = tbl[v].ra1;
            tick();
            chk($sformatf("vec%0d rdat_a0", v), rdat_a[0], tbl[v].ea);
            chk($sformatf("vec%0d rdat_b0", v), rdat_b[0], tbl[v].eb);
            chk($sformatf("vec%0d rvalid_a0", v), 32'(rvalid_a[0]), 32'(tbl[v].eva));
            chk($sformatf("vec%0d rvalid_b0", v), 32'(rvalid_b[0]), 32'(tbl[v].evb));
        end
        idle_inputs();

        // Fill with random data, then clear with traffic applied during the sweep.
        repeat (300) begin
            randomize_inputs(0);
            tick();
        end
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_busy(1'b1, la, lb);
        chk("clr sweep len a", 32'(la), 32'd32);
        chk("clr sweep len b", 32'(lb), 32'd24);
        read_all();

        // Reset in the middle of a sweep restarts it from the beginning.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        async_reset(3);
        rst_n = 1'b1;
        count_busy(1'b0, la, lb);
        chk("restart sweep len a", 32'(la), 32'd32);
        chk("restart sweep len b", 32'(lb), 32'd24);

        // Long random run with occasional clears.
        repeat (2000) begin
            randomize_inputs(64);
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mwmr_ram.md
MWMR_RAM -- requirements
Module: mwmr_ram

Interface
REQ-001 SHALL have parameter ENTRY_CNT, default 32, number of entries (>=2, need not be a power of two).
REQ-002 SHALL have parameter ENTRY_WIDTH, default 32, bits per entry.
REQ-003 SHALL have parameter R_PORT, default 2, number of read ports (>=1).
REQ-004 SHALL have parameter W_PORT, default 2, number of write ports (>=1).
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write data forwarded to reads, 0 = reads return pre-write contents.
REQ-006 SHALL have parameter INIT_VALUE, default 0, ENTRY_WIDTH-bit value written by the clear sweep.
REQ-007 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port wr, input, [W_PORT], per-port write enable.
REQ-010 SHALL have port wadr, input, [W_PORT][AW], per-port write address, AW = $clog2(ENTRY_CNT).
REQ-011 SHALL have port wdat, input, [W_PORT][ENTRY_WIDTH], per-port write data.
REQ-012 SHALL have port rd, input, [R_PORT], per-port read enable.
REQ-013 SHALL have port radr, input, [R_PORT][AW], per-port read address.
REQ-014 SHALL have port rdat, output, [R_PORT][ENTRY_WIDTH], registered read data.
REQ-015 SHALL have port rvalid, output, [R_PORT], high one cycle when rdat[i] updated by an accepted read.
REQ-016 SHALL have port clr, input, 1, single-cycle request to sweep all entries to INIT_VALUE.
REQ-017 SHALL have port busy, output, 1, high while the clear sweep is running.

Function
REQ-018 SHALL implement a two-state FSM: CLEAR (sweep counter cnt, AW bits) and IDLE.
REQ-019 In CLEAR, each cycle SHALL write INIT_VALUE to entry cnt and increment cnt; when cnt = ENTRY_CNT-1 the write completes and the next state SHALL be IDLE with cnt = 0.
REQ-020 A full sweep SHALL take exactly ENTRY_CNT cycles; busy = 1 exactly during those cycles.
REQ-021 In IDLE, clr = 1 SHALL enter CLEAR with cnt = 0 next cycle; clr in CLEAR SHALL be ignored (no restart).
REQ-022 In CLEAR, wr and rd SHALL be ignored: memory changes only via the sweep, rdat holds, rvalid = 0.
REQ-023 In IDLE, wr[j] with wadr[j] < ENTRY_CNT SHALL write wdat[j] to that entry at the clock edge.
REQ-024 Multiple write ports to the same address in one cycle SHALL resolve to the highest-index port; the others are dropped.
REQ-025 In IDLE, rd[i] with radr[i] < ENTRY_CNT SHALL load rdat[i] with the entry at the edge (1-cycle latency) and set rvalid[i] = 1 next cycle.
REQ-026 rd[i] = 0 SHALL hold rdat[i] unchanged and drive rvalid[i] = 0 next cycle.
REQ-027 BYPASS = 1: a read hitting an address written in the same cycle SHALL return the winning write data (REQ-024); BYPASS = 0: it SHALL return the old contents.
REQ-028 Write with wadr >= ENTRY_CNT SHALL be discarded; read with radr >= ENTRY_CNT SHALL return INIT_VALUE with rvalid = 1.
REQ-029 Read ports SHALL be fully independent; any number may address the same entry in one cycle.
REQ-030 Memory array SHALL not be reset directly; initialisation is by the sweep only.

Reset
REQ-031 While rst_n = 0: FSM = CLEAR, cnt = 0, busy = 1, rdat = 0 (all ports), rvalid = 0.
REQ-032 After rst_n rises, the sweep SHALL run immediately; first read/write accepted ENTRY_CNT cycles after the first rising clk edge with rst_n = 1.
REQ-033 rst_n asserted mid-sweep or mid-operation SHALL return to REQ-031 state asynchronously; sweep restarts from 0 after release.

Verification
REQ-034 Reset release, ENTRY_CNT = 32, INIT_VALUE = 0 -> busy high 32 cycles then low; read every entry -> all 0, rvalid pulses 1 cycle each.
REQ-035 IDLE, wr[0] adr 5 = 0xAAAA, wr[1] adr 5 = 0x5555 same cycle -> later read adr 5 returns 0x5555.
REQ-036 BYPASS = 1, wr[0] adr 7 = 0x1234 with rd[0] adr 7 same cycle -> rdat[0] = 0x1234 next cycle; BYPASS = 0 -> previous value.
REQ-037 Fill entries with nonzero data, pulse clr -> busy 32 cycles, wr/rd ignored (rvalid 0), then all entries read INIT_VALUE.
REQ-038 ENTRY_CNT = 24: write adr 30 ignored, read adr 30 -> INIT_VALUE, rvalid = 1; rd = 0 -> rdat holds, rvalid 0.
REQ-039 Assert rst_n low at sweep cycle 10 -> busy stays 1, rdat = 0; after release sweep completes 32 cycles later.
